// File: rtl/bch63326_rx_deframer.sv
// bch63326_rx_deframer: serial bit stream to 63-bit BCH codeword deframer with a held output register and drop accounting.
module bch63326_rx_deframer #(
  parameter int MSB_FIRST  = 1,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  frame_start,
  output logic [62:0]           cw_out,
  output logic                  cw_valid,
  input  logic                  cw_ready,
  output logic                  frame_error,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d, pos, idx;
  logic [62:0]           sr_q, sr_d, cw_q, cw_d;
  logic                  cw_valid_q, cw_valid_d, fe_q, fe_d, ov_q, ov_d;
  logic [DROP_CNT_W-1:0] dc_q, dc_d;
  logic                  take, done, free;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      dc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      cw_q       <= cw_d;
      cw_valid_q <= cw_valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      dc_q       <= dc_d;
    end
  end
  always_comb begin
    take    = bit_valid && (frame_start || state_q == COLLECT);
    pos     = (frame_start || state_q == IDLE) ? 6'd0 : cnt_q;
    done    = take && pos == 6'd62;
    state_d = !take ? state_q : done ? IDLE : COLLECT;
    cnt_d   = !take ? cnt_q : done ? 6'd0 : pos + 6'd1;
  end
  always_comb begin
    idx  = (MSB_FIRST != 0) ? 6'd62 - pos : pos;
    sr_d = (take && frame_start) ? 63'd0 : sr_q;
    if (take) sr_d[idx] = bit_in;
    free       = !cw_valid_q || cw_ready;
    cw_d       = (done && free) ? sr_d : cw_q;
    cw_valid_d = (done && free) || (cw_valid_q && !cw_ready);
    fe_d       = take && frame_start && state_q == COLLECT;
    ov_d       = done && !free;
    dc_d       = (ov_d && !(&dc_q)) ? dc_q + 1'b1 : dc_q;
  end
  assign cw_out      = cw_q;
  assign cw_valid    = cw_valid_q;
  assign frame_error = fe_q;
  assign overflow    = ov_q;
  assign drop_count  = dc_q;
endmodule

// File: tb/tb_bch63326_rx_deframer.sv
// tb_bch63326_rx_deframer: directed and randomized checks of both bit orders against a queue-based frame model.
module tb_bch63326_rx_deframer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, frame_start = 1'b0, cw_ready = 1'b0;
  logic [62:0] cwo_m, cwo_l;
  logic cv_m, cv_l, fe_m, fe_l, ov_m, ov_l;
  logic [7:0] dc_m, dc_l;
  bch63326_rx_deframer #(.MSB_FIRST(1), .DROP_CNT_W(8)) u_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .cw_out(cwo_m), .cw_valid(cv_m), .cw_ready(cw_ready), .frame_error(fe_m),
    .overflow(ov_m), .drop_count(dc_m));
  bch63326_rx_deframer #(.MSB_FIRST(0), .DROP_CNT_W(8)) u_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .cw_out(cwo_l), .cw_valid(cv_l), .cw_ready(cw_ready), .frame_error(fe_l),
    .overflow(ov_l), .drop_count(dc_l));
  int n_cmp = 0, n_err = 0;
  bit q[$];
  bit in_frame = 0, m_v = 0, m_fe = 0, m_ov = 0;
  logic [62:0] m_cm = '0, m_cl = '0;
  int m_dc = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [62:0] rev(input logic [62:0] x);
    logic [62:0] r;
    for (int k = 0; k < 63; k++) r[k] = x[62-k];
    return r;
  endfunction
  task automatic cyc(input logic r, input logic b, input logic v, input logic fs, input logic rd);
    logic [62:0] ncm, ncl;
    bit hs, dn;
    rst = r; bit_in = b; bit_valid = v; frame_start = fs; cw_ready = rd;
    @(posedge clk);
    ncm = '0; ncl = '0; dn = 0;
    if (r) begin
      q.delete(); in_frame = 0; m_v = 0; m_fe = 0; m_ov = 0; m_cm = '0; m_cl = '0; m_dc = 0;
    end else begin
      hs = m_v && rd; m_fe = 0; m_ov = 0;
      if (v) begin
        if (fs) begin
          m_fe = in_frame; q.delete(); q.push_back(b); in_frame = 1;
        end else if (in_frame) q.push_back(b);
        if (q.size() == 63) begin
          dn = 1; in_frame = 0;
          for (int k = 0; k < 63; k++) begin ncm[62-k] = q[k]; ncl[k] = q[k]; end
          q.delete();
        end
      end
      if (dn) begin
        if (!m_v || rd) begin m_cm = ncm; m_cl = ncl; m_v = 1; end
        else begin m_ov = 1; if (m_dc < 255) m_dc++; end
      end else if (hs) m_v = 0;
    end
    #1;
    chk("cw_valid_msb", 64'(cv_m), 64'(m_v));
    chk("cw_valid_lsb", 64'(cv_l), 64'(m_v));
    chk("cw_out_msb", 64'(cwo_m), 64'(m_cm));
    chk("cw_out_lsb", 64'(cwo_l), 64'(m_cl));
    chk("frame_error_msb", 64'(fe_m), 64'(m_fe));
    chk("frame_error_lsb", 64'(fe_l), 64'(m_fe));
    chk("overflow_msb", 64'(ov_m), 64'(m_ov));
    chk("overflow_lsb", 64'(ov_l), 64'(m_ov));
    chk("drop_count_msb", 64'(dc_m), 64'(m_dc));
    chk("drop_count_lsb", 64'(dc_l), 64'(m_dc));
  endtask
  task automatic send(input logic [62:0] w, input int n, input int gap, input logic rd, input logic rd_last);
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(99)) < gap)
        cyc(1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), rd);
      cyc(1'b0, w[62-k], 1'b1, k == 0, (k == n - 1) ? rd_last : rd);
    end
  endtask
  function automatic logic [62:0] rnd63();
    return 63'({$urandom, $urandom});
  endfunction
  initial begin
    logic [62:0] v34, w2, w3, w4, w5, w6, w8;
    v34 = 63'h7FFFFFFF80000001;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_cw_out", 64'(cwo_m), 64'd0);
    chk("reset_drop", 64'(dc_m), 64'd0);
    send(v34, 63, 0, 1'b1, 1'b1);
    chk("r34_valid", 64'(cv_m), 64'd1);
    chk("r34_cw_msb", 64'(cwo_m), 64'(v34));
    chk("r34_cw_lsb", 64'(cwo_l), 64'(rev(v34)));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("r34_single", 64'(cv_m), 64'd0);
    send(v34, 63, 40, 1'b1, 1'b1);
    chk("r35_gap_lsb", 64'(cwo_l), 64'(rev(v34)));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    w2 = rnd63();
    send(rnd63(), 20, 20, 1'b1, 1'b1);
    send(w2, 63, 0, 1'b1, 1'b1);
    chk("r36_cw", 64'(cwo_m), 64'(w2));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    w3 = rnd63(); w4 = rnd63();
    send(w3, 63, 0, 1'b0, 1'b0);
    send(w4, 63, 0, 1'b0, 1'b0);
    chk("r37_drop", 64'(dc_m), 64'd1);
    chk("r37_held", 64'(cwo_m), 64'(w3));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("r37_drained", 64'(cv_m), 64'd0);
    w5 = rnd63(); w6 = rnd63();
    send(w5, 63, 0, 1'b0, 1'b0);
    send(w6, 63, 0, 1'b0, 1'b1);
    chk("r38_cw", 64'(cwo_m), 64'(w6));
    chk("r38_valid", 64'(cv_m), 64'd1);
    chk("r38_no_ovf", 64'(ov_m), 64'd0);
    send(rnd63(), 63, 0, 1'b0, 1'b0);
    send(rnd63(), 40, 10, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("r39_rst_valid", 64'(cv_m), 64'd0);
    w8 = rnd63();
    send(w8, 63, 0, 1'b1, 1'b1);
    chk("r39_clean", 64'(cwo_m), 64'(w8));
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(3))
        cyc(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      send(rnd63(), ($urandom_range(4) == 0) ? int'($urandom_range(62, 1)) : 63,
           int'($urandom_range(30)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 301; f++) send(rnd63(), 63, 0, 1'b0, 1'b0);
    chk("r39_sat", 64'(dc_m), 64'd255);
    chk("r39_sat_lsb", 64'(dc_l), 64'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
